// File: rtl/des_sbox_sequencer.sv
// Runs the eight DES S-box lookups of one round, one per cycle, through a single shared ROM port.
// Optional feature macro SBOX_SEQ_BLK_CNT_EN adds the 16-bit BLK_CNT handshake counter output.
module des_sbox_sequencer #(
  parameter int ROM_LAT = 0
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [47:0] DATA_IN,
  output logic        SBOX_REQ,
  output logic [2:0]  SBOX_SEL,
  output logic [5:0]  SBOX_ADDR,
  input  logic [3:0]  SBOX_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] DATA_OUT
`ifdef SBOX_SEQ_BLK_CNT_EN
  ,
  output logic [15:0] BLK_CNT
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOOKUP, ST_DRAIN, ST_DONE} state_e;

  state_e      state_q, state_d;
  logic [47:0] blk_q;
  logic [2:0]  idx_q;
  logic        req_q;
  logic [2:0]  sel_q;
  logic [5:0]  addr_q;
  logic [31:0] dout_q;
  logic [5:0]  chunk [8];
  logic [2:0]  idx_nxt;
  logic        in_fire, out_fire;
  logic        cap_en;
  logic [2:0]  cap_sel;

  assign in_fire  = IN_VALID && (state_q == ST_IDLE);
  assign out_fire = OUT_READY && (state_q == ST_DONE);
  assign idx_nxt  = idx_q + 3'd1;

  always_comb begin
    for (int k = 0; k < 8; k++) chunk[k] = blk_q[47-6*k -: 6];
  end

  // NOTE: sequential state is written only with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    // NOTE: default assignment first, so no path leaves state_d unassigned and no latch is inferred.
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (in_fire) state_d = ST_LOOKUP;
      ST_LOOKUP: if (idx_q == 3'd7) state_d = (ROM_LAT == 0) ? ST_DONE : ST_DRAIN;
      ST_DRAIN:  state_d = ST_DONE;
      ST_DONE:   if (out_fire) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    IN_READY  = (state_q == ST_IDLE);
    OUT_VALID = (state_q == ST_DONE);
  end

  // Request, select and address are registered one step ahead so the ROM port never glitches.
  // NOTE: the captured block is reset along with the control flops; a mid-block reset leaves nothing stale.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      blk_q  <= '0;
      idx_q  <= '0;
      req_q  <= 1'b0;
      sel_q  <= '0;
      addr_q <= '0;
    end else if (in_fire) begin
      blk_q  <= DATA_IN;
      idx_q  <= '0;
      req_q  <= 1'b1;
      sel_q  <= '0;
      addr_q <= DATA_IN[47:42];
    end else if (state_q == ST_LOOKUP) begin
      idx_q <= idx_nxt;
      if (idx_q == 3'd7) begin
        req_q <= 1'b0;
      end else begin
        sel_q  <= idx_nxt;
        addr_q <= chunk[idx_nxt];
      end
    end
  end

  generate
    if (ROM_LAT == 0) begin : g_lat0
      assign cap_en  = req_q;
      assign cap_sel = sel_q;
    end else begin : g_lat1
      logic       req_d1_q;
      logic [2:0] sel_d1_q;
      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          req_d1_q <= 1'b0;
          sel_d1_q <= '0;
        end else begin
          req_d1_q <= req_q;
          sel_d1_q <= sel_q;
        end
      end
      assign cap_en  = req_d1_q;
      assign cap_sel = sel_d1_q;
    end
  endgenerate

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      dout_q <= '0;
    end else if (cap_en) begin
      for (int k = 0; k < 8; k++) begin
        if (cap_sel == 3'(k)) dout_q[31-4*k -: 4] <= SBOX_DATA;
      end
    end
  end

  assign SBOX_REQ  = req_q;
  assign SBOX_SEL  = sel_q;
  assign SBOX_ADDR = addr_q;
  assign DATA_OUT  = dout_q;

`ifdef SBOX_SEQ_BLK_CNT_EN
  logic [15:0] blk_cnt_q;
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)      blk_cnt_q <= '0;
    else if (out_fire) blk_cnt_q <= blk_cnt_q + 16'd1;
  end
  assign BLK_CNT = blk_cnt_q;
`else
  // Default build: no block counter.
`endif

endmodule
